// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal pipeline: controller state
// encoding, atmospheric-light defaults/limits and the transmission floor.
package haze_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [7:0] A_DEFAULT = 8'd220;
    localparam logic [7:0] A_MIN     = 8'd100;
    localparam logic [7:0] A_MAX     = 8'd240;
    localparam logic [7:0] TX_MIN    = 8'd26;

    function automatic logic [7:0] clamp8(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/frame_geom_checker.sv
// Tracks line/pixel geometry of the dark-channel stream and flags any frame
// whose shape differs from IMG_WIDTH x IMG_HEIGHT.
module frame_geom_checker #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic href,
    input  logic clken,
    input  logic clear,
    input  logic active,
    output logic rise,
    output logic fall,
    output logic pix_en,
    output logic bad
);

    logic        vs_d1;
    logic        hs_d1;
    logic        h_fall;
    logic        geom_bad;
    logic        open_line;
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;

    assign rise   = vsync & ~vs_d1;
    assign fall   = ~vsync & vs_d1;
    assign h_fall = ~href & hs_d1;
    assign pix_en = active & clken & href;

    // A line still open when vsync drops is judged here, one cycle later.
    assign bad = geom_bad
               | (line_cnt != 16'(IMG_HEIGHT))
               | (open_line & (pix_cnt != 16'(IMG_WIDTH)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1     <= 1'b1;
            hs_d1     <= 1'b0;
            geom_bad  <= 1'b0;
            open_line <= 1'b0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
        end else begin
            vs_d1 <= vsync;
            hs_d1 <= href;
            if (clear) begin
                geom_bad  <= 1'b0;
                open_line <= 1'b0;
                pix_cnt   <= '0;
                line_cnt  <= '0;
            end else if (active) begin
                if (clken && href)
                    pix_cnt <= pix_cnt + 16'd1;
                if (h_fall) begin
                    if (pix_cnt != 16'(IMG_WIDTH))
                        geom_bad <= 1'b1;
                    line_cnt <= line_cnt + 16'd1;
                    pix_cnt  <= '0;
                end
                if (fall && href) begin
                    line_cnt  <= line_cnt + 16'd1;
                    open_line <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/atmos_light_ctrl.sv
// Per-frame atmospheric-light estimator: peak of the dark channel, clamped,
// IIR-smoothed against the previous A and published once at frame end.
module atmos_light_ctrl
    import haze_pkg::*;
#(
    parameter int         IMG_WIDTH    = 640,
    parameter int         IMG_HEIGHT   = 480,
    parameter logic [7:0] A_DEFAULT    = haze_pkg::A_DEFAULT,
    parameter logic [7:0] A_MIN        = haze_pkg::A_MIN,
    parameter logic [7:0] A_MAX        = haze_pkg::A_MAX,
    parameter int         SMOOTH_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dark_frame_vsync,
    input  logic        dark_frame_href,
    input  logic        dark_frame_clken,
    input  logic [7:0]  dark_img,
    input  logic        manual_en,
    input  logic [7:0]  manual_a,
    output logic [7:0]  post_A,
    output logic        a_valid,
    output logic        a_update,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int AW = 9 + SMOOTH_SHIFT;

    state_t          state, state_nx;
    logic            clear;
    logic            rise, fall, pix_en, bad;
    logic [7:0]      max_r;
    logic [7:0]      cand;
    logic [7:0]      iir;
    logic [AW-1:0]   acc;

    frame_geom_checker #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_geom (
        .clk    (clk),
        .rst_n  (rst_n),
        .vsync  (dark_frame_vsync),
        .href   (dark_frame_href),
        .clken  (dark_frame_clken),
        .clear  (clear),
        .active (state == ST_ACTIVE),
        .rise   (rise),
        .fall   (fall),
        .pix_en (pix_en),
        .bad    (bad)
    );

    // (9+S)-bit sum cannot overflow: 255*(2^S-1) + 255 < 2^(9+S).
    assign cand = clamp8(max_r, A_MIN, A_MAX);
    assign acc  = AW'(post_A) * AW'((1 << SMOOTH_SHIFT) - 1) + AW'(cand);
    assign iir  = 8'(acc >> SMOOTH_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nx = ST_ACTIVE;
                    clear    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (fall) state_nx = ST_UPDATE;
            end
            ST_UPDATE: begin
                // One-cycle blanking: the next frame starts straight from here.
                if (rise) begin
                    state_nx = ST_ACTIVE;
                    clear    = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r     <= '0;
            post_A    <= A_DEFAULT;
            a_valid   <= 1'b0;
            a_update  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            a_update <= 1'b0;
            if (clear)
                max_r <= '0;
            else if (pix_en && (dark_img > max_r))
                max_r <= dark_img;

            if (state == ST_UPDATE) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (manual_en) begin
                    post_A    <= manual_a;
                    a_valid   <= 1'b1;
                    a_update  <= 1'b1;
                    frame_err <= bad;
                end else if (bad) begin
                    frame_err <= 1'b1;
                end else begin
                    post_A    <= (!a_valid || SMOOTH_SHIFT == 0) ? cand : iir;
                    a_valid   <= 1'b1;
                    a_update  <= 1'b1;
                    frame_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_atmos_light_ctrl.sv
// Directed bench for atmos_light_ctrl on a reduced 8x4 frame; a second
// instance with smoothing disabled shares the same stimulus.
module tb_atmos_light_ctrl;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        clken = 1'b0;
    logic [7:0]  dark_img = 8'd0;
    logic        manual_en = 1'b0;
    logic [7:0]  manual_a = 8'd0;

    logic [7:0]  post_a, post_a0;
    logic        a_valid, a_valid0;
    logic        a_update, a_update0;
    logic        frame_err, frame_err0;
    logic [15:0] frame_cnt, frame_cnt0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    atmos_light_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .A_DEFAULT(8'd220),
        .A_MIN(8'd100), .A_MAX(8'd240), .SMOOTH_SHIFT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dark_frame_vsync(vsync), .dark_frame_href(href), .dark_frame_clken(clken),
        .dark_img(dark_img), .manual_en(manual_en), .manual_a(manual_a),
        .post_A(post_a), .a_valid(a_valid), .a_update(a_update),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    atmos_light_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .A_DEFAULT(8'd220),
        .A_MIN(8'd100), .A_MAX(8'd240), .SMOOTH_SHIFT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .dark_frame_vsync(vsync), .dark_frame_href(href), .dark_frame_clken(clken),
        .dark_img(dark_img), .manual_en(manual_en), .manual_a(manual_a),
        .post_A(post_a0), .a_valid(a_valid0), .a_update(a_update0),
        .frame_err(frame_err0), .frame_cnt(frame_cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; on return vsync has fallen and the DUT is in its update cycle.
    task automatic frame_body(input logic [7:0] peak, input int nlines,
                              input int short_line, input bit open_end);
        int np;
        vsync = 1'b1;
        tick();
        tick();
        for (int l = 0; l < nlines; l++) begin
            np = (l == short_line) ? W - 1 : W;
            href = 1'b1;
            for (int p = 0; p < np; p++) begin
                if (l == 0 && p == 4) begin
                    // Bright value without a strobe must be neither counted nor kept.
                    clken = 1'b0;
                    dark_img = 8'd250;
                    tick();
                end
                clken = 1'b1;
                dark_img = (l == 1 && p == 3) ? peak : 8'd5;
                if (open_end && l == nlines - 1 && p == np - 1) vsync = 1'b0;
                tick();
            end
            if (!(open_end && l == nlines - 1)) begin
                href = 1'b0;
                clken = 1'b0;
                dark_img = 8'd0;
                tick();
                tick();
            end
        end
        if (open_end) begin
            href = 1'b0;
            clken = 1'b0;
            dark_img = 8'd0;
        end else begin
            vsync = 1'b0;
            tick();
        end
    endtask

    // Samples a_update in the update cycle, the following one, and the one after.
    task automatic close_frame(output logic [2:0] pulse);
        pulse[0] = a_update;
        tick();
        pulse[1] = a_update;
        tick();
        pulse[2] = a_update;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [2:0] pl;
        rst_n = 1'b0;
        vsync = 1'b1;
        tick(); tick(); tick();
        if (post_a !== 8'd220) begin bad++; $display("FAIL reset_post_A got=%0d exp=220", post_a); end
        total++;
        if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
        total++;
        if (a_update !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_flags got upd=%b err=%b exp 0/0", a_update, frame_err);
        end
        total++;
        if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        total++;
        rst_n = 1'b1;
        tick(); tick(); tick();
        vsync = 1'b0;
        tick();
        close_frame(pl);
        if (pl !== 3'b000) begin bad++; $display("FAIL midframe_release_pulse got=%b exp=000", pl); end
        total++;
        if (frame_cnt !== 16'd0 || post_a !== 8'd220 || a_valid !== 1'b0) begin
            bad++; $display("FAIL midframe_release_state got cnt=%0d A=%0d v=%b exp 0/220/0",
                            frame_cnt, post_a, a_valid);
        end
        total++;
    endtask

    task automatic test_good_first();
        logic [2:0] pl;
        frame_body(8'd200, H, -1, 1'b0);
        close_frame(pl);
        if (pl !== 3'b010) begin bad++; $display("FAIL first_pulse got=%b exp=010", pl); end
        total++;
        if (post_a !== 8'd200) begin bad++; $display("FAIL first_post_A got=%0d exp=200", post_a); end
        total++;
        if (a_valid !== 1'b1 || frame_err !== 1'b0 || frame_cnt !== 16'd1) begin
            bad++; $display("FAIL first_state got v=%b err=%b cnt=%0d exp 1/0/1", a_valid, frame_err, frame_cnt);
        end
        total++;
    endtask

    task automatic test_smooth();
        logic [2:0] pl;
        frame_body(8'd255, H, -1, 1'b0);
        close_frame(pl);
        if (pl !== 3'b010 || post_a !== 8'd210) begin
            bad++; $display("FAIL smooth_clamp_hi got A=%0d pulse=%b exp 210/010", post_a, pl);
        end
        total++;
        frame_body(8'd50, H, -1, 1'b0);
        close_frame(pl);
        if (post_a !== 8'd182 || frame_cnt !== 16'd3) begin
            bad++; $display("FAIL smooth_clamp_lo got A=%0d cnt=%0d exp 182/3", post_a, frame_cnt);
        end
        total++;
        if (post_a0 !== 8'd100) begin bad++; $display("FAIL s0_clamp_lo got=%0d exp=100", post_a0); end
        total++;
    endtask

    task automatic test_geometry();
        logic [2:0] pl;
        frame_body(8'd200, H, 2, 1'b0);
        close_frame(pl);
        if (pl !== 3'b000 || post_a !== 8'd182) begin
            bad++; $display("FAIL short_line_hold got A=%0d pulse=%b exp 182/000", post_a, pl);
        end
        total++;
        if (frame_err !== 1'b1 || frame_cnt !== 16'd4) begin
            bad++; $display("FAIL short_line_err got err=%b cnt=%0d exp 1/4", frame_err, frame_cnt);
        end
        total++;
        frame_body(8'd200, H - 1, -1, 1'b0);
        close_frame(pl);
        if (pl !== 3'b000 || post_a !== 8'd182 || frame_err !== 1'b1 || frame_cnt !== 16'd5) begin
            bad++; $display("FAIL few_lines got A=%0d pulse=%b err=%b cnt=%0d exp 182/000/1/5",
                            post_a, pl, frame_err, frame_cnt);
        end
        total++;
        frame_body(8'd200, H, -1, 1'b0);
        close_frame(pl);
        if (pl !== 3'b010 || post_a !== 8'd186 || frame_err !== 1'b0 || frame_cnt !== 16'd6) begin
            bad++; $display("FAIL err_clear got A=%0d pulse=%b err=%b cnt=%0d exp 186/010/0/6",
                            post_a, pl, frame_err, frame_cnt);
        end
        total++;
    endtask

    task automatic test_manual();
        logic [2:0] pl;
        manual_en = 1'b1;
        manual_a = 8'd30;
        frame_body(8'd200, H, 1, 1'b0);
        close_frame(pl);
        if (pl !== 3'b010 || post_a !== 8'd30 || frame_err !== 1'b1) begin
            bad++; $display("FAIL manual_bad_geom got A=%0d pulse=%b err=%b exp 30/010/1", post_a, pl, frame_err);
        end
        total++;
        if (post_a0 !== 8'd30) begin bad++; $display("FAIL s0_manual got=%0d exp=30", post_a0); end
        total++;
        manual_en = 1'b0;
        frame_body(8'd240, H, -1, 1'b0);
        close_frame(pl);
        if (post_a !== 8'd82 || frame_err !== 1'b0 || frame_cnt !== 16'd8) begin
            bad++; $display("FAIL after_manual got A=%0d err=%b cnt=%0d exp 82/0/8", post_a, frame_err, frame_cnt);
        end
        total++;
    endtask

    task automatic test_open_line();
        logic [2:0] pl;
        frame_body(8'd100, H, -1, 1'b1);
        close_frame(pl);
        if (pl !== 3'b010 || post_a !== 8'd86 || frame_err !== 1'b0) begin
            bad++; $display("FAIL open_line got A=%0d pulse=%b err=%b exp 86/010/0", post_a, pl, frame_err);
        end
        total++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] pl;
        logic       p0, p1;
        frame_body(8'd200, H, -1, 1'b0);
        p0 = a_update;
        vsync = 1'b1;
        tick();
        p1 = a_update;
        if (p0 !== 1'b0 || p1 !== 1'b1 || post_a !== 8'd114) begin
            bad++; $display("FAIL b2b_first got A=%0d p0=%b p1=%b exp 114/0/1", post_a, p0, p1);
        end
        total++;
        frame_body(8'd255, H, -1, 1'b0);
        close_frame(pl);
        if (pl !== 3'b010 || post_a !== 8'd145 || frame_cnt !== 16'd11) begin
            bad++; $display("FAIL b2b_second got A=%0d pulse=%b cnt=%0d exp 145/010/11", post_a, pl, frame_cnt);
        end
        total++;
        if (post_a0 !== 8'd240) begin bad++; $display("FAIL s0_b2b got=%0d exp=240", post_a0); end
        total++;
    endtask

    task automatic test_s0();
        logic [2:0] pl;
        frame_body(8'd130, H, -1, 1'b0);
        close_frame(pl);
        if (post_a0 !== 8'd130 || frame_cnt0 !== 16'd12) begin
            bad++; $display("FAIL s0_plain got A=%0d cnt=%0d exp 130/12", post_a0, frame_cnt0);
        end
        total++;
        if (post_a !== 8'd141) begin bad++; $display("FAIL s2_last got=%0d exp=141", post_a); end
        total++;
    endtask

    initial begin
        test_reset();
        test_good_first();
        test_smooth();
        test_geometry();
        test_manual();
        test_open_line();
        test_back_to_back();
        test_s0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
